wb_arbiter: RTL and testbench

Write-back arbiter driving the register file's single write port. Accepts results from the ALU path and the load (memory) path through valid/ready handshakes, buffers load results in a small FIFO, and issues at most one registered write per cycle on the register file's rd / write_data / write_enable inputs. Also exports a pending-write mask that the hazard unit uses to stall readers of registers with queued loads.

---
 rtl/wb_pkg.sv | 10 +
 rtl/wb_fifo.sv | 59 +++++
 rtl/wb_arbiter.sv | 97 +++++++++
 tb/tb_wb_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and write-back request type for wb_arbiter
package wb_pkg;
  localparam int REG_AW_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic [REG_AW_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of wb_req_t exposing per-entry valid/rd for hazard tracking
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  wb_req_t                         push_req,
  input  logic                            pop,
  output wb_req_t                         head,
  output logic                            full,
  output logic                            empty,
  output logic [CW-1:0]                   count,
  output logic [DEPTH-1:0]                ent_valid,
  output logic [DEPTH-1:0][REG_AW_DEF-1:0] ent_rd
);

  wb_req_t        mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // full is judged on the pre-edge count, so a pop never frees room for a same-edge push
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end

  // An entry is live when its distance from the read pointer is below count
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = CW'(PW'(PW'(i) - rd_ptr)) < count;
      ent_rd[i]    = mem[i].rd;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter: load FIFO ahead of ALU, one registered write per cycle
// Optional: WB_ZERO_DISCARD_EN suppresses write_enable for rd==0 and clears pending[0].
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int MEM_FIFO_DEPTH = 4,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int REG_AW         = REG_AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [REG_AW-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [REG_AW-1:0]    mem_rd,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 mem_ready,
  output logic [REG_AW-1:0]    rd,
  output logic [DATA_W-1:0]    write_data,
  output logic                 write_enable,
  output logic [2**REG_AW-1:0] pending
);

  localparam int CW = $clog2(MEM_FIFO_DEPTH + 1);

  wb_req_t                                push_req;
  wb_req_t                                head;
  logic                                   fifo_full;
  logic                                   fifo_empty;
  logic [CW-1:0]                          fifo_count;
  logic [MEM_FIFO_DEPTH-1:0]              ent_valid;
  logic [MEM_FIFO_DEPTH-1:0][REG_AW-1:0]  ent_rd;
  logic                                   push;
  logic                                   pop;
  logic                                   head_en;
  logic                                   alu_en;

  assign push_req  = '{rd: mem_rd, data: mem_data};
  assign alu_ready = (fifo_count == '0);
  assign mem_ready = !fifo_full;
  assign push      = mem_valid && !fifo_full && !rst;
  assign pop       = !fifo_empty && !rst;

`ifdef WB_ZERO_DISCARD_EN
  assign head_en = (head.rd != '0);
  assign alu_en  = (alu_rd != '0);
`else
  assign head_en = 1'b1;
  assign alu_en  = 1'b1;
`endif

  wb_fifo #(.DEPTH(MEM_FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_req  (push_req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  // Queued loads are older than any ALU result, so they always win the port
  always_ff @(posedge clk) begin
    if (rst) begin
      rd           <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
    end else if (!fifo_empty) begin
      rd           <= head.rd;
      write_data   <= head.data;
      write_enable <= head_en;
    end else if (alu_valid) begin
      rd           <= alu_rd;
      write_data   <= alu_data;
      write_enable <= alu_en;
    end else begin
      write_enable <= 1'b0;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < MEM_FIFO_DEPTH; i++) begin
      if (ent_valid[i]) pending[ent_rd[i]] = 1'b1;
    end
`ifdef WB_ZERO_DISCARD_EN
    pending[0] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized scoreboard bench for wb_arbiter against a queue-based model
module tb_wb_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] pending;

  wb_arbiter #(.MEM_FIFO_DEPTH(DEPTH), .DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rd(rd), .write_data(write_data), .write_enable(write_enable), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } ld_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; int at_cyc; } exp_t;

  ld_t  mq[$];
  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].rd] = 1'b1;
`ifdef WB_ZERO_DISCARD_EN
    p[0] = 1'b0;
`endif
    return p;
  endfunction

  function automatic bit writes(input logic [4:0] r);
`ifdef WB_ZERO_DISCARD_EN
    return r != 5'd0;
`else
    return 1'b1;
`endif
  endfunction

  // One cycle: drive at negedge, check readies/pending, then advance the model across the edge
  task automatic step(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      output logic a_acc, output logic m_acc);
    exp_t e;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    check("alu_ready", alu_ready, mq.size() == 0);
    check("mem_ready", mem_ready, mq.size() != DEPTH);
    check("pending", pending, model_pending());
    a_acc = 1'b0;
    m_acc = 1'b0;
    if (r) begin
      mq.delete();
    end else begin
      a_acc = av && (mq.size() == 0);
      m_acc = mv && (mq.size() != DEPTH);
      e.at_cyc = cyc + 1;
      if (mq.size() != 0) begin
        e.rd = mq[0].rd; e.data = mq[0].data;
        void'(mq.pop_front());
        if (writes(e.rd)) exp_q.push_back(e);
      end else if (a_acc) begin
        e.rd = ard; e.data = ad;
        if (writes(e.rd)) exp_q.push_back(e);
      end
      if (m_acc) mq.push_back('{rd: mrd, data: md});
    end
  endtask

  // Monitor: every expected write must appear on exactly its cycle, and no others
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (write_enable) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_enable", write_enable, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("wr_rd", rd, e.rd);
          check("wr_data", write_data, e.data);
          check("wr_cycle", cyc, e.at_cyc);
        end
      end else if (exp_q.size() != 0 && exp_q[0].at_cyc <= cyc) begin
        e = exp_q.pop_front();
        check("missing_write_cycle", cyc, e.at_cyc - 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic aa, ma;
    int tries;
    rst = 1'b1; alu_valid = 0; mem_valid = 0;
    alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0;

    step(1, 0, 0, 0, 0, 0, 0, aa, ma);
    step(1, 0, 0, 0, 0, 0, 0, aa, ma);
    step(0, 0, 0, 0, 0, 0, 0, aa, ma);
    check("reset_rd", rd, 5'd0);
    check("reset_write_data", write_data, 32'd0);
    check("reset_write_enable", write_enable, 1'b0);

    step(0, 1, 5, 32'h1234_5678, 0, 0, 0, aa, ma);
    check("alu_single_accept", aa, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, aa, ma);
    step(0, 0, 0, 0, 0, 0, 0, aa, ma);

    step(0, 1, 3, 32'hA, 1, 4, 32'hB, aa, ma);
    check("simul_alu_accept", aa, 1'b1);
    check("simul_mem_accept", ma, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, aa, ma);
    step(0, 0, 0, 0, 0, 0, 0, aa, ma);

    // Back-to-back loads with the ALU held valid until it is accepted
    for (int i = 0; i < 5; i++) begin
      tries = 0;
      ma = 0;
      while (!ma && tries < 20) begin
        step(0, 1, 7, 32'hC0DE, 1, 5'(8 + i), 32'h100 + i, aa, ma);
        tries++;
      end
      check("fill_load_accepted", ma, 1'b1);
    end
    tries = 0;
    aa = 0;
    while (!aa && tries < 20) begin
      step(0, 1, 7, 32'hC0DE, 0, 0, 0, aa, ma);
      tries++;
    end
    check("fill_alu_accepted", aa, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, aa, ma);

    for (int i = 0; i < 10; i++) begin
      tries = 0;
      ma = 0;
      while (!ma && tries < 20) begin
        step(0, 0, 0, 0, 1, 5'(i + 1), i, aa, ma);
        tries++;
      end
    end
    step(0, 0, 0, 0, 0, 0, 0, aa, ma);
    step(0, 0, 0, 0, 0, 0, 0, aa, ma);

    // Reset while a load is queued: it must be dropped
    step(0, 1, 9, 32'h99, 1, 10, 32'hAA, aa, ma);
    step(1, 0, 0, 0, 0, 0, 0, aa, ma);
    step(0, 0, 0, 0, 0, 0, 0, aa, ma);
    step(0, 0, 0, 0, 0, 0, 0, aa, ma);

    step(0, 1, 0, 32'hFF, 0, 0, 0, aa, ma);
    check("zero_reg_alu_accept", aa, 1'b1);
    step(0, 1, 0, 32'hFF, 1, 0, 32'hEE, aa, ma);
    step(0, 0, 0, 0, 0, 0, 0, aa, ma);
    step(0, 0, 0, 0, 0, 0, 0, aa, ma);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(63) == 0, 1'($urandom), 5'($urandom), $urandom,
           1'($urandom), 5'($urandom), $urandom, aa, ma);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, aa, ma);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
